alu_io_sequencer: RTL

- Front-end and back-end stage wrapped around the 8-bit ALU-with-flags block.
- Collects operand A, operand B and an op byte serially from the 8-bit input pins using a strobed handshake, then drives the ALU's combinational inputs.
- Captures the ALU result and its N/Z/C/V flags into registers and presents them on the 8-bit output pins, selectable by a select input.
- Makes the combinational ALU usable through the pin-limited chip top level.

---
 rtl/alu_io_pkg.sv | 37 +++
 rtl/alu_io_sequencer_if.sv | 32 +++
 rtl/alu_io_sequencer_strobe_sync_edge.sv | 28 ++
 rtl/alu_io_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_io_pkg.sv
// Shared types and field positions for the ALU I/O sequencer.
package alu_io_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetB,
    StGetOp,
    StExec,
    StDone
  } state_e;

  // Flags byte layout
  localparam int unsigned FLG_V   = 0;
  localparam int unsigned FLG_C   = 1;
  localparam int unsigned FLG_Z   = 2;
  localparam int unsigned FLG_N   = 3;
  localparam int unsigned CNT_LSB = 4;

  // Op byte fields; bits [7:6] are don't-care
  localparam int unsigned CTRL_LSB  = 0;
  localparam int unsigned CTRL_W    = 3;
  localparam int unsigned SHAMT_LSB = 3;
  localparam int unsigned SHAMT_W   = 3;

  function automatic logic [7:0] pack_flags(input logic [3:0] cnt, input logic n,
                                            input logic z, input logic c, input logic v);
    logic [7:0] f;
    f = '0;
    f[CNT_LSB +: 4] = cnt;
    f[FLG_N]        = n;
    f[FLG_Z]        = z;
    f[FLG_C]        = c;
    f[FLG_V]        = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_io_sequencer_if.sv
// Pin-side byte handshake plus ALU-side operand/result bus.
interface alu_io_sequencer_if;
  logic       ena;
  logic [7:0] data_in;
  logic       load;
  logic       out_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [2:0] alu_shamt;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_v;
  logic       alu_n;
  logic       alu_z;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic [1:0] phase;

  // Environment side: pins and the ALU
  modport master (
    output ena, data_in, load, out_sel, alu_res, alu_c, alu_v, alu_n, alu_z,
    input  alu_a, alu_b, alu_ctrl, alu_shamt, data_out, valid, busy, phase
  );

  // Sequencer side
  modport slave (
    input  ena, data_in, load, out_sel, alu_res, alu_c, alu_v, alu_n, alu_z,
    output alu_a, alu_b, alu_ctrl, alu_shamt, data_out, valid, busy, phase
  );
endinterface

// File: rtl/alu_io_sequencer_strobe_sync_edge.sv
// Synchronizer chain on an asynchronous strobe followed by a rising-edge detector.
module strobe_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw strobe through the chain; remember last synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse on rising edge only
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_io_sequencer.sv
// Serial byte loader for the ALU operands/op and registered result/flags presenter.
module alu_io_sequencer
  import alu_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  alu_io_sequencer_if.slave bus
);

  logic       load_pulse;
  logic       pulse;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [2:0] shamt_q, shamt_d;
  logic [7:0] res_q, res_d;
  logic [7:0] flags_q, flags_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic [7:0] dout_q, dout_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic [1:0] phase_q, phase_d;

  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe_i(bus.load),
    .pulse_o (load_pulse)
  );

  // A strobe seen while disabled is lost, not deferred
  assign pulse   = load_pulse & bus.ena;
  assign cnt_inc = cnt_q + 4'd1;

  // Next-state: byte collection, execute capture and output mux
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    shamt_d = shamt_q;
    res_d   = res_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    phase_d = phase_q;

    case (state_q)
      StIdle, StDone: begin
        if (pulse) begin
          a_d     = bus.data_in;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          phase_d = 2'd1;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (pulse) begin
          b_d     = bus.data_in;
          phase_d = 2'd2;
          state_d = StGetOp;
        end
      end
      StGetOp: begin
        if (pulse) begin
          ctrl_d  = bus.data_in[CTRL_LSB +: CTRL_W];
          shamt_d = bus.data_in[SHAMT_LSB +: SHAMT_W];
          state_d = StExec;
        end
      end
      StExec: begin
        // Any pulse here is dropped; capture waits for ena
        if (bus.ena) begin
          res_d   = bus.alu_res;
          flags_d = pack_flags(cnt_inc, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v);
          cnt_d   = cnt_inc;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          phase_d = 2'd0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    // Output only tracks the mux while a completed result is valid
    dout_d = valid_q ? (bus.out_sel ? flags_q : res_q) : dout_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      shamt_q <= '0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      shamt_q <= shamt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.alu_shamt = shamt_q;
  assign bus.data_out  = dout_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.phase     = phase_q;

endmodule
